// File: rtl/cus19_ctrl_pkg.sv
// cus19_ctrl_pkg: op codes, pc_src encodings and flag bit indices shared with the PC unit
package cus19_ctrl_pkg;
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BEQ  = 3'b010;
  localparam logic [2:0] OP_BNE  = 3'b011;
  localparam logic [2:0] OP_BC   = 3'b100;
  localparam logic [2:0] OP_BN   = 3'b101;
  localparam logic [2:0] OP_CALL = 3'b110;
  localparam logic [2:0] OP_RET  = 3'b111;
  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_JMP  = 2'b01;
  localparam logic [1:0] PCSRC_CALL = 2'b10;
  localparam logic [1:0] PCSRC_RET  = 2'b11;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
endpackage

// File: rtl/cus19_cond_eval.sv
// cus19_cond_eval: conditional-branch taken decision from op and effective {N,C,Z}
module cus19_cond_eval
  import cus19_ctrl_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic [2:0] flags_i,
  output logic       taken_o
);
  always_comb begin
    taken_o = (op_i == OP_BEQ) ?  flags_i[FLAG_Z] :
              (op_i == OP_BNE) ? ~flags_i[FLAG_Z] :
              (op_i == OP_BC)  ?  flags_i[FLAG_C] :
              (op_i == OP_BN)  ?  flags_i[FLAG_N] : 1'b0;
  end
endmodule

// File: rtl/cus19_branch_ctrl.sv
// cus19_branch_ctrl: registered control-flow resolution driving the IF-stage PC mux
module cus19_branch_ctrl
  import cus19_ctrl_pkg::*;
#(
  parameter int PC_Width     = 11,
  parameter int Stack_Depth  = 8,
  parameter int Flush_Cycles = 2,
  localparam int DW = $clog2(Stack_Depth + 1)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                ctrl_valid_in,
  input  logic [2:0]          ctrl_op_in,
  input  logic [PC_Width-1:0] target_in,
  input  logic                flag_we_in,
  input  logic [2:0]          flags_in,
  input  logic                fault_clr_in,
  output logic                branch_out,
  output logic [1:0]          pc_src_out,
  output logic [PC_Width-1:0] imm_add_out,
  output logic                flush_out,
  output logic [DW-1:0]       depth_out,
  output logic                ovf_fault_out,
  output logic                unf_fault_out
);
  localparam logic [DW-1:0] FULL = DW'(Stack_Depth);
  localparam logic [1:0]    FLUSH_LOAD = 2'(Flush_Cycles);
  logic [2:0]          flags_q, eff_flags;
  logic [1:0]          fcnt_q, fcnt_d, pc_src_d;
  logic [DW-1:0]       depth_q, depth_d;
  logic [PC_Width-1:0] imm_q, imm_d;
  logic                branch_q, branch_d, ovf_q, ovf_d, unf_q, unf_d;
  logic                acc, taken, call_ok, ret_ok, redirect, is_call, is_ret;
  assign eff_flags = flag_we_in ? flags_in : flags_q;
  cus19_cond_eval u_cond (
    .op_i   (ctrl_op_in),
    .flags_i(eff_flags),
    .taken_o(taken)
  );
  // Ops seen while a flush is pending are wrong-path and must leave no trace.
  always_comb begin
    acc      = ctrl_valid_in && (fcnt_q == 2'd0);
    is_call  = acc && (ctrl_op_in == OP_CALL);
    is_ret   = acc && (ctrl_op_in == OP_RET);
    call_ok  = is_call && (depth_q != FULL);
    ret_ok   = is_ret && (depth_q != '0);
    branch_d = acc && taken;
    pc_src_d = (acc && ctrl_op_in == OP_JMP) ? PCSRC_JMP :
               call_ok ? PCSRC_CALL :
               ret_ok  ? PCSRC_RET  : PCSRC_SEQ;
    redirect = branch_d || (pc_src_d != PCSRC_SEQ);
    imm_d    = acc ? target_in : imm_q;
    depth_d  = call_ok ? depth_q + 1'b1 : ret_ok ? depth_q - 1'b1 : depth_q;
    fcnt_d   = redirect ? FLUSH_LOAD : (fcnt_q != 2'd0) ? fcnt_q - 2'd1 : 2'd0;
    ovf_d    = (is_call && !call_ok) || (ovf_q && !fault_clr_in);
    unf_d    = (is_ret && !ret_ok) || (unf_q && !fault_clr_in);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      flags_q    <= '0;
      fcnt_q     <= '0;
      depth_q    <= '0;
      imm_q      <= '0;
      branch_q   <= 1'b0;
      pc_src_out <= PCSRC_SEQ;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      flags_q    <= eff_flags;
      fcnt_q     <= fcnt_d;
      depth_q    <= depth_d;
      imm_q      <= imm_d;
      branch_q   <= branch_d;
      pc_src_out <= pc_src_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end
  assign branch_out    = branch_q;
  assign imm_add_out   = imm_q;
  assign flush_out     = fcnt_q != 2'd0;
  assign depth_out     = depth_q;
  assign ovf_fault_out = ovf_q;
  assign unf_fault_out = unf_q;
endmodule

// File: tb/tb_cus19_branch_ctrl.sv
// tb_cus19_branch_ctrl: directed self-checking bench for cus19_branch_ctrl
module tb_cus19_branch_ctrl;
  logic        clk = 1'b0, rst = 1'b0, valid = 1'b0, fwe = 1'b0, fclr = 1'b0;
  logic [2:0]  op = 3'b000, flags = 3'b000;
  logic [10:0] target = '0;
  logic        branch, flush, ovf, unf;
  logic [1:0]  pc_src;
  logic [10:0] imm;
  logic [3:0]  depth;
  int tests = 0, fails = 0;
  cus19_branch_ctrl dut (
    .clk_in(clk), .rst_in(rst), .ctrl_valid_in(valid), .ctrl_op_in(op),
    .target_in(target), .flag_we_in(fwe), .flags_in(flags), .fault_clr_in(fclr),
    .branch_out(branch), .pc_src_out(pc_src), .imm_add_out(imm), .flush_out(flush),
    .depth_out(depth), .ovf_fault_out(ovf), .unf_fault_out(unf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [2:0] o, input logic [10:0] t);
    valid = v; op = o; target = t;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
    valid = 1'b0; op = 3'b000; fwe = 1'b0; fclr = 1'b0; rst = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    rst = 1'b1;
    step();
    chk("rst_branch", {31'd0, branch}, 0);
    chk("rst_pcsrc", {30'd0, pc_src}, 0);
    chk("rst_imm", {21'd0, imm}, 0);
    chk("rst_flush", {31'd0, flush}, 0);
    chk("rst_depth", {28'd0, depth}, 0);
    chk("rst_faults", {30'd0, ovf, unf}, 0);
    drive(1, 3'b001, 11'h123);
    step();
    chk("jmp_pcsrc", {30'd0, pc_src}, 1);
    chk("jmp_imm", {21'd0, imm}, 32'h123);
    chk("jmp_flush1", {31'd0, flush}, 1);
    drive(1, 3'b010, 11'h055); fwe = 1'b1; flags = 3'b001;
    step();
    chk("wrongpath_branch", {31'd0, branch}, 0);
    chk("wrongpath_pcsrc", {30'd0, pc_src}, 0);
    chk("wrongpath_imm", {21'd0, imm}, 32'h123);
    chk("jmp_flush2", {31'd0, flush}, 1);
    step();
    chk("jmp_flush_end", {31'd0, flush}, 0);
    drive(1, 3'b010, 11'h040); fwe = 1'b1; flags = 3'b001;
    step();
    chk("beq_bypass_taken", {31'd0, branch}, 1);
    chk("beq_pcsrc", {30'd0, pc_src}, 0);
    chk("beq_imm", {21'd0, imm}, 32'h040);
    chk("beq_flush", {31'd0, flush}, 1);
    step();
    chk("beq_branch_drop", {31'd0, branch}, 0);
    step();
    drive(1, 3'b011, 11'h077);
    step();
    chk("bne_not_taken", {31'd0, branch}, 0);
    chk("bne_no_flush", {31'd0, flush}, 0);
    chk("bne_imm", {21'd0, imm}, 32'h077);
    for (int i = 1; i <= 8; i++) begin
      drive(1, 3'b110, 11'(i));
      step();
      chk("call_pcsrc", {30'd0, pc_src}, 2);
      chk("call_depth", {28'd0, depth}, i);
      idle(3);
    end
    drive(1, 3'b110, 11'h3FF);
    step();
    chk("call9_pcsrc", {30'd0, pc_src}, 0);
    chk("call9_ovf", {31'd0, ovf}, 1);
    chk("call9_depth", {28'd0, depth}, 8);
    chk("call9_no_flush", {31'd0, flush}, 0);
    rst = 1'b1;
    step();
    chk("rst2_ovf", {31'd0, ovf}, 0);
    drive(1, 3'b111, 11'h010);
    step();
    chk("ret0_pcsrc", {30'd0, pc_src}, 0);
    chk("ret0_unf", {31'd0, unf}, 1);
    chk("ret0_no_flush", {31'd0, flush}, 0);
    fclr = 1'b1;
    step();
    chk("unf_cleared", {31'd0, unf}, 0);
    drive(1, 3'b111, 11'h011); fclr = 1'b1;
    step();
    chk("unf_wins_clr", {31'd0, unf}, 1);
    drive(1, 3'b110, 11'h200);
    step();
    chk("call_ret_pc1", {30'd0, pc_src}, 2);
    chk("call_ret_d1", {28'd0, depth}, 1);
    chk("call_ret_imm", {21'd0, imm}, 32'h200);
    idle(2);
    drive(1, 3'b111, 11'h000);
    step();
    chk("call_ret_pc2", {30'd0, pc_src}, 3);
    chk("call_ret_d0", {28'd0, depth}, 0);
    idle(2);
    drive(1, 3'b110, 11'h155);
    step();
    chk("pre_rst_depth", {28'd0, depth}, 1);
    step();
    chk("pre_rst_flush2", {31'd0, flush}, 1);
    rst = 1'b1;
    step();
    chk("midflush_rst_flush", {31'd0, flush}, 0);
    chk("midflush_rst_depth", {28'd0, depth}, 0);
    chk("midflush_rst_pcsrc", {30'd0, pc_src}, 0);
    chk("midflush_rst_imm", {21'd0, imm}, 0);
    chk("midflush_rst_faults", {30'd0, ovf, unf}, 0);
    drive(1, 3'b001, 11'h0AA);
    step();
    chk("post_rst_accept", {30'd0, pc_src}, 1);
    chk("post_rst_imm", {21'd0, imm}, 32'h0AA);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
